// File: rtl/truth_table_pkg.sv
// Shared definitions for the programmable truth-table engine.
// Holds the sequencer state encoding and the helper that sizes the
// column-select port from the number of stored functions.
package truth_table_pkg;

  // IDLE serves single evaluations and config writes; SWEEP walks every
  // input row; DONE is the one-cycle end-of-sweep marker.
  typedef enum logic [1:0] {
    TT_IDLE  = 2'd0,
    TT_SWEEP = 2'd1,
    TT_DONE  = 2'd2
  } tt_state_e;

  // A single function still needs a one-bit select so the port exists.
  function automatic int calcSelW(input int nOut);
    return (nOut <= 1) ? 1 : $clog2(nOut);
  endfunction

endpackage

// File: rtl/tt_row_lookup.sv
// Combinational row lookup for the truth-table engine.
// Ports:
//   table_i  - flat table, column j occupies bits [j*2^N_IN +: 2^N_IN]
//   row_i    - input row index (row_i[N_IN-1] is the MSB input)
//   result_o - bit j is function j evaluated at row_i
module tt_row_lookup #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 10
) (
  input  logic [N_OUT*(1<<N_IN)-1:0] table_i,
  input  logic [N_IN-1:0]            row_i,
  output logic [N_OUT-1:0]           result_o
);

  localparam int ROWS = 1 << N_IN;

  // Each function is its own column; pick the addressed bit of every column.
  for (genvar g = 0; g < N_OUT; g++) begin : gCol
    logic [ROWS-1:0] column;
    assign column      = table_i[g*ROWS +: ROWS];
    assign result_o[g] = column[row_i];
  end

endmodule

// File: rtl/truth_table_engine.sv
// Programmable multi-output truth-table evaluator.
// Stores N_OUT loadable columns of 2^N_IN bits and answers either single
// evaluation requests or an autonomous sweep of every input row, with a
// one-deep registered output under valid/ready backpressure.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   cfg_we/cfg_sel/cfg_col     - column write (accepted only while cfg_ready)
//   cfg_ready                  - high in IDLE
//   in_valid/in_ready/in_vec   - single evaluation request
//   start                      - sweep request
//   busy, done                 - sweep in progress / one-cycle end pulse
//   out_valid/out_ready        - result handshake
//   out_row/out_vec/out_last   - result row, function vector, final beat flag
module truth_table_engine
  import truth_table_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 10,
  parameter int SEL_W = calcSelW(N_OUT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [SEL_W-1:0]     cfg_sel,
  input  logic [(1<<N_IN)-1:0] cfg_col,
  output logic                 cfg_ready,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN-1:0]      in_vec,
  input  logic                 start,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_IN-1:0]      out_row,
  output logic [N_OUT-1:0]     out_vec,
  output logic                 out_last,
  output logic                 done
);

  localparam int ROWS = 1 << N_IN;

  tt_state_e             state_q, state_d;
  logic [N_IN-1:0]       rowCnt_q, rowCnt_d;
  logic [N_OUT*ROWS-1:0] table_q, table_d;
  logic                  outValid_q, outValid_d;
  logic                  outLast_q, outLast_d;
  logic [N_IN-1:0]       outRow_q, outRow_d;
  logic [N_OUT-1:0]      outVec_q, outVec_d;

  logic                  outFree;
  logic                  evalAccept;
  logic                  startAccept;
  logic                  sweepLoad;
  logic                  lastAccept;
  logic [N_IN-1:0]       lookupRow;
  logic [N_OUT-1:0]      lookupVec;

  // The output register can take new data when empty or being drained.
  assign outFree     = !outValid_q || out_ready;
  assign evalAccept  = in_valid && in_ready;
  // An evaluation request always wins over a simultaneous start.
  assign startAccept = (state_q == TT_IDLE) && start && !in_valid && outFree;
  // The register is empty when a sweep begins, so a pending beat with
  // out_last set inside SWEEP can only be the final row; stop loading then.
  assign sweepLoad   = (state_q == TT_SWEEP) && outFree && !(outValid_q && outLast_q);
  assign lastAccept  = (state_q == TT_SWEEP) && outValid_q && outLast_q && out_ready;

  assign lookupRow = (state_q == TT_SWEEP) ? rowCnt_q : in_vec;

  // Lookups always see the registered table, so a same-cycle write only
  // affects later evaluations.
  tt_row_lookup #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_lookup (
    .table_i  (table_q),
    .row_i    (lookupRow),
    .result_o (lookupVec)
  );

  // Next-state logic of the IDLE -> SWEEP -> DONE sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TT_IDLE:  if (startAccept) state_d = TT_SWEEP;
      TT_SWEEP: if (lastAccept)  state_d = TT_DONE;
      TT_DONE:  state_d = TT_IDLE;
      default:  state_d = TT_IDLE;
    endcase
  end

  // Status outputs decoded from state and the output register occupancy.
  always_comb begin
    cfg_ready = (state_q == TT_IDLE);
    in_ready  = (state_q == TT_IDLE) && outFree;
    busy      = (state_q == TT_SWEEP) || (state_q == TT_DONE);
    done      = (state_q == TT_DONE);
  end

  // Column writes are ignored outside IDLE and for selects past N_OUT-1.
  always_comb begin
    table_d = table_q;
    if (cfg_we && (state_q == TT_IDLE)) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (cfg_sel == SEL_W'(j)) table_d[j*ROWS +: ROWS] = cfg_col;
      end
    end
  end

  // Row counter and output register; data holds whenever nothing loads.
  always_comb begin
    rowCnt_d   = rowCnt_q;
    outValid_d = outValid_q;
    outRow_d   = outRow_q;
    outVec_d   = outVec_q;
    outLast_d  = outLast_q;
    if (startAccept) rowCnt_d = '0;
    if (evalAccept) begin
      outValid_d = 1'b1;
      outRow_d   = in_vec;
      outVec_d   = lookupVec;
      outLast_d  = 1'b1;
    end else if (sweepLoad) begin
      outValid_d = 1'b1;
      outRow_d   = rowCnt_q;
      outVec_d   = lookupVec;
      outLast_d  = &rowCnt_q;
      rowCnt_d   = rowCnt_q + N_IN'(1);
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // All state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= TT_IDLE;
      rowCnt_q   <= '0;
      table_q    <= '0;
      outValid_q <= 1'b0;
      outRow_q   <= '0;
      outVec_q   <= '0;
      outLast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rowCnt_q   <= rowCnt_d;
      table_q    <= table_d;
      outValid_q <= outValid_d;
      outRow_q   <= outRow_d;
      outVec_q   <= outVec_d;
      outLast_q  <= outLast_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_row   = outRow_q;
  assign out_vec   = outVec_q;
  assign out_last  = outLast_q;

endmodule

// File: tb/tb_truth_table_engine.sv
// Self-checking bench for truth_table_engine with default parameters.
// Expected beats are queued when stimulus is issued; a monitor pops and
// compares them on every output transfer.
module tb_truth_table_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [3:0]  cfg_sel;
  logic [15:0] cfg_col;
  logic        cfg_ready;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_vec;
  logic        start;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_row;
  logic [9:0]  out_vec;
  logic        out_last;
  logic        done;

  typedef struct packed {
    logic [3:0] row;
    logic [9:0] vec;
    logic       last;
  } beat_t;

  beat_t       sbQ[$];
  logic [15:0] modelCols [10];
  logic [15:0] initCols  [10];
  int          testsRun   = 0;
  int          failCount  = 0;
  int          beatCount  = 0;
  int          doneCount  = 0;
  int          cycleCount = 0;

  truth_table_engine #(.N_IN(4), .N_OUT(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_col   (cfg_col),
    .cfg_ready (cfg_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_vec   (out_vec),
    .out_last  (out_last),
    .done      (done)
  );

  // Free-running clock and a cycle counter used for latency checks.
  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [9:0] modelVec(input logic [3:0] row);
    logic [9:0] v;
    for (int j = 0; j < 10; j++) v[j] = modelCols[j][row];
    return v;
  endfunction

  // Monitor: a transfer is visible at the negedge before the accepting edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      beat_t exp;
      beatCount++;
      if (sbQ.size() == 0) begin
        testsRun++;
        failCount++;
        $display("[TB] FAIL unexpected_beat: got row %0d vec 0x%0h, expected no beat", out_row, out_vec);
      end else begin
        exp = sbQ.pop_front();
        checkOutput("beat_row",  32'(out_row),  32'(exp.row));
        checkOutput("beat_vec",  32'(out_vec),  32'(exp.vec));
        checkOutput("beat_last", 32'(out_last), 32'(exp.last));
      end
    end
    if (done) doneCount++;
  end

  // Hard stop in case something deadlocks outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfgWrite(input logic [3:0] sel, input logic [15:0] col);
    cfg_we  = 1'b1;
    cfg_sel = sel;
    cfg_col = col;
    tick();
    cfg_we = 1'b0;
    if (sel < 4'd10) modelCols[sel] = col;
  endtask

  task automatic applyStimulus(input logic [3:0] vec, input logic [9:0] expVec);
    sbQ.push_back('{row: vec, vec: expVec, last: 1'b1});
    in_valid = 1'b1;
    in_vec   = vec;
    checkOutput("eval_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("eval_latency", 32'(out_valid), 32'd1);
  endtask

  task automatic runSweep(input int stallRow, input int stallCycles,
                          input bit cfgDuring, input int expCycles);
    int k;
    int startBeats;
    int stallsLeft;
    bit doneSeen;
    for (int r = 0; r < 16; r++)
      sbQ.push_back('{row: 4'(r), vec: modelVec(4'(r)), last: 1'(r == 15)});
    startBeats = beatCount;
    stallsLeft = stallCycles;
    doneSeen   = 1'b0;
    out_ready  = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    k = cycleCount;
    checkOutput("sweep_busy_on_start", 32'(busy), 32'd1);
    checkOutput("sweep_in_ready_low", 32'(in_ready), 32'd0);
    checkOutput("sweep_first_empty", 32'(out_valid), 32'd0);
    for (int i = 0; i < 200; i++) begin
      tick();
      cfg_we = 1'b0;
      if (done) begin
        doneSeen = 1'b1;
        break;
      end
      if (cfgDuring && i == 4) begin
        cfg_we  = 1'b1;
        cfg_sel = 4'd2;
        cfg_col = 16'hFFFF;
        checkOutput("cfg_ready_in_sweep", 32'(cfg_ready), 32'd0);
      end
      if (stallCycles > 0 && out_valid && out_row == 4'(stallRow)) begin
        checkOutput("hold_vec",  32'(out_vec),  32'(modelVec(4'(stallRow))));
        checkOutput("hold_last", 32'(out_last), 32'd0);
      end
      if (stallCycles > 0 && out_valid && out_row == 4'(stallRow) && stallsLeft > 0) begin
        out_ready = 1'b0;
        stallsLeft--;
      end else begin
        out_ready = 1'b1;
      end
    end
    out_ready = 1'b1;
    if (!doneSeen) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL sweep_timeout: got no done, expected done");
    end
    checkOutput("sweep_done_cycle", 32'(cycleCount - k), 32'(expCycles));
    checkOutput("sweep_beats", 32'(beatCount - startBeats), 32'd16);
    checkOutput("busy_in_done", 32'(busy), 32'd1);
    tick();
    checkOutput("done_pulse_width", 32'(done), 32'd0);
    checkOutput("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int  startBeats;
    int  doneBefore;
    bit  found;
    initCols = '{16'hAAAA, 16'hF8D8, 16'hCCCC, 16'hF0F0, 16'hFF00,
                 16'h8001, 16'h6996, 16'h0F0F, 16'h1234, 16'hFFFF};
    for (int j = 0; j < 10; j++) modelCols[j] = 16'h0000;
    reset     = 1'b1;
    cfg_we    = 1'b0;
    cfg_sel   = 4'd0;
    cfg_col   = 16'h0000;
    in_valid  = 1'b0;
    in_vec    = 4'd0;
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    // Reset values.
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_row",   32'(out_row),   32'd0);
    checkOutput("rst_out_vec",   32'(out_vec),   32'd0);
    checkOutput("rst_out_last",  32'(out_last),  32'd0);
    checkOutput("rst_done",      32'(done),      32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    reset = 1'b0;
    tick();

    // Single evaluation of wx + xz' + yz stored in function 1.
    cfgWrite(4'd1, 16'hF8D8);
    applyStimulus(4'b0110, 10'b00_0000_0010);
    applyStimulus(4'b0101, 10'b00_0000_0000);
    tick();

    // Full sweep without backpressure.
    for (int j = 0; j < 10; j++) cfgWrite(4'(j), initCols[j]);
    runSweep(-1, 0, 1'b0, 17);

    // Sweep with three stall cycles on row 5, plus a dropped write mid-sweep.
    runSweep(5, 3, 1'b1, 20);
    applyStimulus(4'd0, modelVec(4'd0));
    applyStimulus(4'd9, modelVec(4'd9));

    // Out-of-range select leaves the table alone.
    cfgWrite(4'd10, 16'hFFFF);
    applyStimulus(4'd0, modelVec(4'd0));
    applyStimulus(4'd6, modelVec(4'd6));

    // Write and evaluation in the same cycle: evaluation sees the old column.
    sbQ.push_back('{row: 4'd1, vec: modelVec(4'd1), last: 1'b1});
    cfg_we   = 1'b1;
    cfg_sel  = 4'd0;
    cfg_col  = 16'h5555;
    in_valid = 1'b1;
    in_vec   = 4'd1;
    tick();
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    modelCols[0] = 16'h5555;
    applyStimulus(4'd1, modelVec(4'd1));
    tick();

    // Simultaneous start and evaluation: only the evaluation is served.
    startBeats = beatCount;
    sbQ.push_back('{row: 4'd12, vec: modelVec(4'd12), last: 1'b1});
    start    = 1'b1;
    in_valid = 1'b1;
    in_vec   = 4'd12;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    checkOutput("simul_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    checkOutput("simul_busy_later", 32'(busy), 32'd0);
    checkOutput("simul_beats", 32'(beatCount - startBeats), 32'd1);

    // Reset in the middle of a sweep at row 7.
    for (int r = 0; r < 16; r++)
      sbQ.push_back('{row: 4'(r), vec: modelVec(4'(r)), last: 1'(r == 15)});
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (out_valid && out_row == 4'd7) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL reach_row7: got no row 7, expected row 7");
    end
    reset = 1'b1;
    sbQ.delete();
    for (int j = 0; j < 10; j++) modelCols[j] = 16'h0000;
    doneBefore = doneCount;
    tick();
    reset = 1'b0;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_busy",      32'(busy),      32'd0);
    checkOutput("midrst_out_vec",   32'(out_vec),   32'd0);
    checkOutput("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
    repeat (20) tick();
    checkOutput("midrst_no_done", 32'(doneCount - doneBefore), 32'd0);
    applyStimulus(4'd3, 10'b00_0000_0000);
    repeat (3) tick();

    checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
